// File: rtl/alu_muldiv_sequencer_pkg.sv
// Shared constants for the multi-cycle multiply/divide sequencer: ALU opcodes,
// request op codes and FSM state encoding.
package alu_muldiv_sequencer_pkg;

   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;
   localparam logic [2:0] ALU_SL  = 3'd4;
   localparam logic [2:0] ALU_SRL = 3'd5;
   localparam logic [2:0] ALU_SRA = 3'd6;
   localparam logic [2:0] ALU_SLT = 3'd7;

   localparam logic OP_MUL  = 1'b0;
   localparam logic OP_DIVU = 1'b1;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_MUL_ITER = 2'd1;
   localparam logic [1:0] ST_DIV_ITER = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

endpackage

// File: rtl/alu_muldiv_sequencer.sv
// Unsigned shift-add multiply / restoring divide sequencer that borrows the shared
// ALU for one add or subtract per cycle while busy.
module alu_muldiv_sequencer
   import alu_muldiv_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] alu_result
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   logic [1:0]       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   // work_hi: MUL accumulator high half / DIVU remainder
   // work_lo: MUL multiplier+product low half / DIVU quotient
   // opnd:    MUL multiplicand / DIVU divisor
   logic [WIDTH-1:0] work_hi_q, work_hi_d;
   logic [WIDTH-1:0] work_lo_q, work_lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   logic [WIDTH-1:0] res_lo_q, res_lo_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] mul_sum;
   logic             mul_carry;
   logic [WIDTH:0]   div_shift;
   logic             div_take;
   logic             last_iter;

   // ALU ownership: driven only while iterating, parked at AND/zero otherwise.
   always_comb begin
      alu_in1     = '0;
      alu_in2     = '0;
      alu_control = ALU_AND;
      if (state_q == ST_MUL_ITER) begin
         alu_in1     = work_hi_q;
         alu_in2     = opnd_q;
         alu_control = ALU_ADD;
      end else if (state_q == ST_DIV_ITER) begin
         alu_in1     = div_shift[WIDTH-1:0];
         alu_in2     = opnd_q;
         alu_control = ALU_SUB;
      end
   end

   always_comb begin
      // The ALU result is modulo 2^WIDTH, so carry comes from a local compare.
      mul_sum   = work_lo_q[0] ? alu_result : work_hi_q;
      mul_carry = work_lo_q[0] & (alu_result < work_hi_q);
      div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
      div_take  = div_shift[WIDTH] | (div_shift[WIDTH-1:0] >= opnd_q);
      last_iter = (cnt_q == CntW'(1));

      state_d   = state_q;
      cnt_d     = cnt_q;
      work_hi_d = work_hi_q;
      work_lo_d = work_lo_q;
      opnd_d    = opnd_q;
      res_hi_d  = res_hi_q;
      res_lo_d  = res_lo_q;
      dbz_d     = dbz_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               cnt_d     = CntW'(WIDTH);
               work_hi_d = '0;
               dbz_d     = 1'b0;
               if (op == OP_MUL) begin
                  work_lo_d = operand_b;
                  opnd_d    = operand_a;
                  state_d   = ST_MUL_ITER;
               end else if (operand_b == '0) begin
                  res_hi_d = operand_a;
                  res_lo_d = '1;
                  dbz_d    = 1'b1;
                  state_d  = ST_DONE;
               end else begin
                  work_lo_d = operand_a;
                  opnd_d    = operand_b;
                  state_d   = ST_DIV_ITER;
               end
            end
         end
         ST_MUL_ITER: begin
            work_hi_d = {mul_carry, mul_sum[WIDTH-1:1]};
            work_lo_d = {mul_sum[0], work_lo_q[WIDTH-1:1]};
            cnt_d     = cnt_q - CntW'(1);
            if (last_iter) begin
               res_hi_d = work_hi_d;
               res_lo_d = work_lo_d;
               state_d  = ST_DONE;
            end
         end
         ST_DIV_ITER: begin
            work_hi_d = div_take ? alu_result : div_shift[WIDTH-1:0];
            work_lo_d = {work_lo_q[WIDTH-2:0], div_take};
            cnt_d     = cnt_q - CntW'(1);
            if (last_iter) begin
               res_hi_d = work_hi_d;
               res_lo_d = work_lo_d;
               state_d  = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         work_hi_q <= '0;
         work_lo_q <= '0;
         opnd_q    <= '0;
         res_hi_q  <= '0;
         res_lo_q  <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_hi_q <= work_hi_d;
         work_lo_q <= work_lo_d;
         opnd_q    <= opnd_d;
         res_hi_q  <= res_hi_d;
         res_lo_q  <= res_lo_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy        = (state_q == ST_MUL_ITER) || (state_q == ST_DIV_ITER);
   assign done        = (state_q == ST_DONE);
   assign div_by_zero = dbz_q;
   assign result_hi   = res_hi_q;
   assign result_lo   = res_lo_q;

endmodule
